// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: PORTS x WIDTH pins with output latch, direction,
// atomic set/clear and synchronised inputs. Edge flags/IRQ built only with GPIO_IRQ_EN.
module gpio_bank #(
  parameter int PORTS       = 2,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   raw_clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   write_enable,
  input  logic [5:0]             address,
  input  logic [15:0]            data_in,
  output logic [15:0]            data_out,
  input  logic [PORTS*WIDTH-1:0] gpio_in,
  output logic [PORTS*WIDTH-1:0] gpio_out,
  output logic [PORTS*WIDTH-1:0] gpio_oe,
  output logic                   irq
);

  localparam int PW = PORTS * WIDTH;

  logic                             wr_en;
  logic                             rd_en;
  logic [1:0]                       port_sel;
  logic [2:0]                       reg_sel;
  logic [WIDTH-1:0]                 wdata;
  logic [PORTS-1:0][WIDTH-1:0]      out_q;
  logic [PORTS-1:0][WIDTH-1:0]      dir_q;
  logic [SYNC_STAGES-1:0][PW-1:0]   sync_q;
  logic [PW-1:0]                    sync_now;
  logic [15:0]                      rd_data;
  logic                             unused_data;

  assign wr_en       = enable & write_enable;
  assign rd_en       = enable & ~write_enable;
  assign port_sel    = address[4:3];
  assign reg_sel     = address[2:0];
  assign wdata       = data_in[WIDTH-1:0];
  assign sync_now    = sync_q[SYNC_STAGES-1];
  assign gpio_out    = out_q;
  assign gpio_oe     = dir_q;
  assign unused_data = ^data_in;

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
    end
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
      dir_q <= '0;
    end else if (wr_en && !address[5]) begin
      for (int p = 0; p < PORTS; p++) begin
        if (port_sel == 2'(p)) begin
          case (reg_sel)
            3'd0:    out_q[p] <= wdata;
            3'd1:    dir_q[p] <= wdata;
            3'd6:    out_q[p] <= out_q[p] | wdata;
            3'd7:    out_q[p] <= out_q[p] & ~wdata;
            default: ;
          endcase
        end
      end
    end
  end

`ifdef GPIO_IRQ_EN
  localparam int PCW = $clog2(SYNC_STAGES + 2);

  logic [PW-1:0]                hist_q;
  logic [PW-1:0]                rise;
  logic [PW-1:0]                fall;
  logic [PCW-1:0]               prime_q;
  logic                         edge_ok;
  logic [PORTS-1:0][WIDTH-1:0]  rise_en_q;
  logic [PORTS-1:0][WIDTH-1:0]  fall_en_q;
  logic [PORTS-1:0][WIDTH-1:0]  flags_q;
  logic [PORTS-1:0][WIDTH-1:0]  flag_set;
  logic [PORTS-1:0][WIDTH-1:0]  flag_clr;
  logic [PORTS-1:0]             irq_mask_q;
  logic [PORTS-1:0]             irq_pend;

  assign rise    = sync_now & ~hist_q;
  assign fall    = ~sync_now & hist_q;
  // history is meaningless until the synchroniser has filled after reset
  assign edge_ok = (prime_q == '0);

  always_comb begin
    flag_set = '0;
    flag_clr = '0;
    irq_pend = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (edge_ok) begin
        flag_set[p] = (rise[p*WIDTH +: WIDTH] & rise_en_q[p]) |
                      (fall[p*WIDTH +: WIDTH] & fall_en_q[p]);
      end
      if (wr_en && !address[5] && port_sel == 2'(p) && reg_sel == 3'd5) begin
        flag_clr[p] = wdata;
      end
      irq_pend[p] = |flags_q[p];
    end
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q     <= '0;
      prime_q    <= PCW'(SYNC_STAGES + 1);
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      flags_q    <= '0;
      irq_mask_q <= '0;
      irq        <= 1'b0;
    end else begin
      hist_q <= sync_now;
      if (prime_q != '0) begin
        prime_q <= prime_q - 1'b1;
      end
      // set is OR-ed after the clear so a same-cycle edge survives W1C
      flags_q <= (flags_q & ~flag_clr) | flag_set;
      irq     <= |(irq_pend & irq_mask_q);
      if (wr_en && !address[5]) begin
        for (int p = 0; p < PORTS; p++) begin
          if (port_sel == 2'(p)) begin
            case (reg_sel)
              3'd3:    rise_en_q[p] <= wdata;
              3'd4:    fall_en_q[p] <= wdata;
              default: ;
            endcase
          end
        end
      end
      if (wr_en && address == 6'h21) begin
        irq_mask_q <= data_in[PORTS-1:0];
      end
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    if (!address[5]) begin
      for (int p = 0; p < PORTS; p++) begin
        if (port_sel == 2'(p)) begin
          case (reg_sel)
            3'd0:    rd_data[WIDTH-1:0] = out_q[p];
            3'd1:    rd_data[WIDTH-1:0] = dir_q[p];
            3'd2:    rd_data[WIDTH-1:0] = sync_now[p*WIDTH +: WIDTH];
`ifdef GPIO_IRQ_EN
            3'd3:    rd_data[WIDTH-1:0] = rise_en_q[p];
            3'd4:    rd_data[WIDTH-1:0] = fall_en_q[p];
            3'd5:    rd_data[WIDTH-1:0] = flags_q[p];
`endif
            default: ;
          endcase
        end
      end
    end
`ifdef GPIO_IRQ_EN
    else if (address == 6'h20) begin
      rd_data[PORTS-1:0] = irq_pend;
    end else if (address == 6'h21) begin
      rd_data[PORTS-1:0] = irq_mask_q;
    end
`endif
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
    end else if (rd_en) begin
      data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: directed steps plus random bus traffic
// compared against a pin-history reference model of the register map.
module tb_gpio_bank;
  localparam int PORTS = 2;
  localparam int WIDTH = 8;
  localparam int SS    = 2;
  localparam int PW    = PORTS * WIDTH;
`ifdef GPIO_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic            raw_clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            enable = 1'b0;
  logic            write_enable = 1'b0;
  logic [5:0]      address = '0;
  logic [15:0]     data_in = '0;
  logic [15:0]     data_out;
  logic [PW-1:0]   gpio_in = '0;
  logic [PW-1:0]   gpio_out;
  logic [PW-1:0]   gpio_oe;
  logic            irq;

  always #5 raw_clk = ~raw_clk;

  gpio_bank #(.PORTS(PORTS), .WIDTH(WIDTH), .SYNC_STAGES(SS)) dut (
    .raw_clk(raw_clk), .reset_n(reset_n), .enable(enable),
    .write_enable(write_enable), .address(address), .data_in(data_in),
    .data_out(data_out), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: register contents plus the pin value present at each edge
  logic [WIDTH-1:0] m_out[PORTS];
  logic [WIDTH-1:0] m_dir[PORTS];
  logic [WIDTH-1:0] m_rise[PORTS];
  logic [WIDTH-1:0] m_fall[PORTS];
  logic [WIDTH-1:0] m_flags[PORTS];
  logic [PORTS-1:0] m_mask;
  logic [15:0]      exp_dout;
  logic             exp_irq;
  int               edges;
  logic [PW-1:0]    pin_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] pins_at(input int back);
    return pin_q[pin_q.size() - 1 - back];
  endfunction

  function automatic logic [15:0] m_read(input logic [5:0] a);
    logic [15:0]   r;
    logic [PW-1:0] pv;
    int            p;
    r  = '0;
    pv = pins_at(SS);
    if (!a[5]) begin
      p = int'(a[4:3]);
      if (p < PORTS) begin
        case (a[2:0])
          3'd0: r[WIDTH-1:0] = m_out[p];
          3'd1: r[WIDTH-1:0] = m_dir[p];
          3'd2: r[WIDTH-1:0] = pv[p*WIDTH +: WIDTH];
          3'd3: if (IRQ_ON) r[WIDTH-1:0] = m_rise[p];
          3'd4: if (IRQ_ON) r[WIDTH-1:0] = m_fall[p];
          3'd5: if (IRQ_ON) r[WIDTH-1:0] = m_flags[p];
          default: r = '0;
        endcase
      end
    end else if (IRQ_ON) begin
      if (a == 6'h20) for (int q = 0; q < PORTS; q++) r[q] = (m_flags[q] != '0);
      if (a == 6'h21) r[PORTS-1:0] = m_mask;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int q = 0; q < PORTS; q++) begin
      m_out[q] = '0; m_dir[q] = '0; m_rise[q] = '0; m_fall[q] = '0; m_flags[q] = '0;
    end
    m_mask   = '0;
    exp_dout = '0;
    exp_irq  = 1'b0;
    edges    = 0;
    pin_q.delete();
    repeat (SS + 2) pin_q.push_back('0);
  endtask

  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    #2;
    chk({tag, "_gpio_out"}, 64'(gpio_out), 64'(0));
    chk({tag, "_gpio_oe"},  64'(gpio_oe),  64'(0));
    chk({tag, "_data_out"}, 64'(data_out), 64'(0));
    chk({tag, "_irq"},      64'(irq),      64'(0));
    @(posedge raw_clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic cycle(input logic en, input logic we, input logic [5:0] a, input logic [15:0] d);
    logic [PW-1:0]    cur, prev, eo, eoe;
    logic [WIDTH-1:0] wd, setb, clrb;
    logic             nxt_irq;
    int               p;
    enable = en; write_enable = we; address = a; data_in = d;
    wd = d[WIDTH-1:0];
    pin_q.push_back(gpio_in);
    if (pin_q.size() > 16) void'(pin_q.pop_front());
    edges++;
    if (en && !we) exp_dout = m_read(a);
    nxt_irq = 1'b0;
    for (int q = 0; q < PORTS; q++) if (m_mask[q] && m_flags[q] != '0) nxt_irq = IRQ_ON;
    cur  = pins_at(SS);
    prev = pins_at(SS + 1);
    for (int q = 0; q < PORTS; q++) begin
      setb = '0;
      if (IRQ_ON && edges >= SS + 2)
        setb = (cur[q*WIDTH +: WIDTH] & ~prev[q*WIDTH +: WIDTH] & m_rise[q]) |
               (~cur[q*WIDTH +: WIDTH] & prev[q*WIDTH +: WIDTH] & m_fall[q]);
      clrb = (en && we && a == 6'(8*q + 5)) ? wd : '0;
      m_flags[q] = (m_flags[q] & ~clrb) | setb;
    end
    if (en && we) begin
      p = int'(a[4:3]);
      if (!a[5] && p < PORTS) begin
        case (a[2:0])
          3'd0: m_out[p] = wd;
          3'd1: m_dir[p] = wd;
          3'd3: if (IRQ_ON) m_rise[p] = wd;
          3'd4: if (IRQ_ON) m_fall[p] = wd;
          3'd6: m_out[p] = m_out[p] | wd;
          3'd7: m_out[p] = m_out[p] & ~wd;
          default: ;
        endcase
      end else if (IRQ_ON && a == 6'h21) begin
        m_mask = d[PORTS-1:0];
      end
    end
    @(posedge raw_clk); #1;
    exp_irq = nxt_irq;
    for (int q = 0; q < PORTS; q++) begin
      eo[q*WIDTH +: WIDTH]  = m_out[q];
      eoe[q*WIDTH +: WIDTH] = m_dir[q];
    end
    chk("gpio_out", 64'(gpio_out), 64'(eo));
    chk("gpio_oe",  64'(gpio_oe),  64'(eoe));
    chk("data_out", 64'(data_out), 64'(exp_dout));
    chk("irq",      64'(irq),      64'(exp_irq));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, 6'h00, 16'h0000);
  endtask

  initial begin
    logic [5:0] ra;
    model_reset();

    // reset with all pins high, then no spurious edge after priming
    gpio_in = '1;
    apply_reset("rst");
    cycle(1, 1, 6'h03, 16'h00FF);
    idle(9);
    cycle(1, 0, 6'h05, 16'h0000);
    chk("flags_after_prime", 64'(data_out), 64'h0000);
    cycle(1, 0, 6'h02, 16'h0000);
    chk("in0_all_high", 64'(data_out), 64'h00FF);

    // OUT / SET / CLR
    cycle(1, 1, 6'h00, 16'h00A5);
    chk("out_write", 64'(gpio_out[7:0]), 64'hA5);
    cycle(1, 1, 6'h06, 16'h0F00);
    chk("set_upper_ignored", 64'(gpio_out[7:0]), 64'hA5);
    cycle(1, 1, 6'h07, 16'h0001);
    chk("clr_bit0", 64'(gpio_out[7:0]), 64'hA4);
    cycle(1, 0, 6'h00, 16'h0000);
    chk("out0_read", 64'(data_out), 64'h00A4);

    // back-to-back writes then reads
    cycle(1, 1, 6'h09, 16'h0006);
    cycle(1, 1, 6'h08, 16'h0080);
    chk("oe1", 64'(gpio_oe[15:8]), 64'h06);
    cycle(1, 0, 6'h09, 16'h0000);
    chk("dir1_read", 64'(data_out), 64'h0006);
    cycle(1, 0, 6'h08, 16'h0000);
    chk("out1_read", 64'(data_out), 64'h0080);
    cycle(1, 0, 6'h28, 16'h0000);
    chk("unmapped_read", 64'(data_out), 64'h0000);

    // single rising edge on pin 0 -> flag at edge 3, irq at edge 4
    gpio_in = '0;
    idle(4);
    cycle(1, 1, 6'h03, 16'h0001);
    cycle(1, 1, 6'h21, 16'h0001);
    idle(3);
    gpio_in[0] = 1'b1;
    idle(3);
    chk("irq_edge3", 64'(irq), 64'(0));
    idle(1);
    chk("irq_edge4", 64'(irq), 64'(IRQ_ON));
    cycle(1, 0, 6'h05, 16'h0000);
    chk("flags0_rise", 64'(data_out), 64'(IRQ_ON));
    cycle(1, 0, 6'h20, 16'h0000);
    chk("irq_pend", 64'(data_out), 64'(IRQ_ON));
    cycle(1, 1, 6'h05, 16'h0001);
    chk("irq_w1c_edge1", 64'(irq), 64'(IRQ_ON));
    idle(1);
    chk("irq_w1c_edge2", 64'(irq), 64'(0));

    // W1C colliding with a fresh rising edge
    gpio_in[0] = 1'b0; idle(4);
    gpio_in[0] = 1'b1; idle(4);
    chk("irq_rearm", 64'(irq), 64'(IRQ_ON));
    gpio_in[0] = 1'b0; idle(4);
    gpio_in[0] = 1'b1; idle(2);
    cycle(1, 1, 6'h05, 16'h0001);
    chk("collide_irq", 64'(irq), 64'(IRQ_ON));
    idle(1);
    chk("collide_irq_hold", 64'(irq), 64'(IRQ_ON));
    cycle(1, 0, 6'h05, 16'h0000);
    chk("collide_flags", 64'(data_out), 64'(IRQ_ON));

    // reset in the middle of a write: write lost, data_out cleared
    cycle(1, 0, 6'h00, 16'h0000);
    enable = 1'b1; write_enable = 1'b1; address = 6'h00; data_in = 16'h005A;
    apply_reset("rst_mid");
    cycle(1, 0, 6'h00, 16'h0000);
    chk("write_lost", 64'(data_out), 64'h0000);

    // random bus traffic and pin activity
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) gpio_in = PW'($urandom);
      if ($urandom_range(0, 9) == 0) ra = 6'h20 + 6'($urandom_range(0, 3));
      else ra = {1'b0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
      cycle(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), ra, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
